muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the MIPS integer datapath. Implements MULT/MULTU/DIV/DIVU with HI/LO registers, plus MTHI/MTLO writes. Reuses the 32-bit adder structure the ALU uses, stepping one radix-2 iteration per cycle. Sits beside the ALU in EX. Pipeline control stalls on busy.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each.
ITER, WIDTH, iterations per operation; fixed equal to WIDTH.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  request operation; accepted only when busy=0
MDOp  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start
A  in  WIDTH  rs operand (multiplicand / dividend)
B  in  WIDTH  rt operand (multiplier / divisor)
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse: HI/LO just updated by an operation
HI  out  WIDTH  HI register (direct register output)
LO  out  WIDTH  LO register (direct register output)

Behaviour:
- Reset: state IDLE, busy=0, done=0, HI=0, LO=0, counter=0, operand regs=0. Reset mid-operation aborts it; HI/LO return to 0 and no done pulse is issued.
- FSM:
  - IDLE: start=1 -> PREP; latch |A|, |B| (signed ops) or A, B (unsigned); latch result signs.
  - PREP: clear accumulator, counter=0 -> RUN.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. Counter increments; after ITER steps -> FIX.
  - FIX: apply sign correction, write HI/LO -> IDLE with done=1 for the next cycle.
- Latency: start accepted at edge E0; busy=1 from E0 through E(ITER+2); HI/LO updated and done=1 at E(ITER+2). That is 34 cycles for WIDTH=32. Back-to-back start is allowed in the cycle done is high.
- start while busy=1 is ignored and not queued. Pipeline holds the instruction until busy=0.
- mthi/mtlo apply only when busy=0 and take effect next edge. While busy=1 they are dropped. If mthi/mtlo and start coincide in IDLE, the write happens and the operation later overwrites both HI and LO.
- mult/multu: {HI,LO} = 64-bit product. Signed result is negated iff sign(A)^sign(B).
- div/divu: LO = quotient, HI = remainder.
  - Signed quotient sign = sign(A)^sign(B); remainder sign = sign(A).
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero: LO=0xFFFFFFFF (divu) or the sign-corrected all-ones (div), HI=A. No exception.
- The 0x80000000 magnitude is handled as an unsigned WIDTH-bit value; no extra bit is needed.

Optional Feature:
MULDIV_DIV0_FLAG_EN:
- Defined: adds output div0 (1 bit). It is set in the done cycle of a div/divu whose latched B==0, and cleared on the next start or on reset.
- Undefined: the port is absent; divide-by-zero behaviour is otherwise identical.

Decomposition:
- Package muldiv_pkg holds:
  - MDOp codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
  - FSM state encoding ST_IDLE, ST_PREP, ST_RUN, ST_FIX
  - WIDTH default
- Sub-module muldiv_step: combinational single iteration. Inputs: partial remainder/accumulator, operand, mode. Outputs: next accumulator, next shift register, quotient bit. Built on adder_32bits.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=5 -> after 34 cycles, done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly 34 cycles.
- multu A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=100, B=7 -> LO=14, HI=2. Then div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234; with MULDIV_DIV0_FLAG_EN, div0=1 in the done cycle, then 0 after the next start.
- mthi 0xAAAA while busy -> HI unchanged at done. mtlo 0x55 while idle -> LO=0x55 next cycle. start asserted mid-operation -> ignored, only one done.
- reset asserted at RUN cycle 10 -> next cycle busy=0, HI=LO=0, no done. A fresh mult 6*7 then gives LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes, FSM state encoding and the default operand width.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_RUN  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

    // Signed variants (MULT, DIV) have a clear low opcode bit.
    function automatic logic md_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/adder_32bits.sv
// Ripple-style adder shared with the ALU: sum plus carry out.
module adder_32bits #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// shift-subtract for divide, both built on the shared adder.
// In divide mode shreg_o has a zero in bit 0; the caller inserts qbit_o.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] shreg_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic             div_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] shreg_o,
    output logic             qbit_o
);

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] rem_sh;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_sh = {acc_i[WIDTH-2:0], shreg_i[WIDTH-1]};

    // Adder operand selection: acc + multiplicand, or rem - divisor.
    always_comb begin
        add_a = acc_i;
        add_b = '0;
        if (div_i) begin
            add_a = rem_sh;
            add_b = ~operand_i;
        end else if (shreg_i[0]) begin
            add_b = operand_i;
        end
    end

    adder_32bits #(.WIDTH(WIDTH)) u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (div_i),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Result formation; a set top remainder bit means the shifted value
    // already exceeds WIDTH bits, so the subtract always succeeds.
    always_comb begin
        qbit_o  = 1'b0;
        acc_o   = {cout, sum[WIDTH-1:1]};
        shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
        if (div_i) begin
            qbit_o  = acc_i[WIDTH-1] | cout;
            acc_o   = qbit_o ? sum : rem_sh;
            shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO and MTHI/MTLO.
// Optional macro MULDIV_DIV0_FLAG_EN adds a sticky divide-by-zero flag
// output div0, set at completion and cleared by the next start.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    output logic             div0
`endif
);

    localparam int CW = $clog2(ITER + 1);
    localparam int PW = 2 * WIDTH;

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic             done_q, done_d;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0_q, div0_d;
`endif

    logic             is_div;
    logic             start_signed;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] step_acc, step_sh;
    logic             step_qbit;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign is_div       = op_q[1];
    assign start_signed = md_is_signed(md_op_e'(MDOp));
    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign a_abs = (start_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
    assign b_abs = (start_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

    assign prod_fix = neg_lo_q ? (~{acc_q, sh_q} + PW'(1)) : {acc_q, sh_q};
    assign quo_fix  = neg_lo_q ? (~sh_q + WIDTH'(1)) : sh_q;
    assign rem_fix  = neg_hi_q ? (~acc_q + WIDTH'(1)) : acc_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .shreg_i   (sh_q),
        .operand_i (is_div ? b_q : a_q),
        .div_i     (is_div),
        .acc_o     (step_acc),
        .shreg_o   (step_sh),
        .qbit_o    (step_qbit)
    );

    // Next-state, datapath and HI/LO write logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
        div0_d   = div0_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start) begin
                    state_d  = ST_PREP;
                    op_d     = md_op_e'(MDOp);
                    a_d      = a_abs;
                    b_d      = b_abs;
                    neg_lo_d = start_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_hi_d = start_signed & A[WIDTH-1];
`ifdef MULDIV_DIV0_FLAG_EN
                    div0_d   = 1'b0;
`endif
                end
            end
            ST_PREP: begin
                acc_d   = '0;
                sh_d    = is_div ? a_q : b_q;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                acc_d = step_acc;
                sh_d  = {step_sh[WIDTH-1:1], is_div ? step_qbit : step_sh[0]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
`ifdef MULDIV_DIV0_FLAG_EN
                div0_d  = is_div && (b_q == '0);
`endif
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation and clears HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MULT;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV0_FLAG_EN
            div0_q   <= div0_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
    assign div0 = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed and random operations are
// predicted with plain 64-bit arithmetic; a monitor checks every done.
module tb_muldiv_seq;

    localparam int W    = 32;
    localparam int ITER = 32;

    logic          clk = 1'b0;
    logic          reset, start, mthi, mtlo;
    logic [1:0]    MDOp;
    logic [W-1:0]  A, B, wdata;
    logic          busy, done;
    logic [W-1:0]  HI, LO;
`ifdef MULDIV_DIV0_FLAG_EN
    logic          div0;
`endif

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    muldiv_seq #(.WIDTH(W), .ITER(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
`ifdef MULDIV_DIV0_FLAG_EN
        ,
        .div0  (div0)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference: MIPS HI/LO results from whole-number arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.d0 = op[1] && (b == 32'd0);
        case (op)
            2'b00: begin p = sa * sb; {e.hi, e.lo} = p; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = up; end
            2'b10: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                mon_e = exp_q.pop_front();
                check("HI", {32'd0, HI}, {32'd0, mon_e.hi});
                check("LO", {32'd0, LO}, {32'd0, mon_e.lo});
`ifdef MULDIV_DIV0_FLAG_EN
                check("div0", {63'd0, div0}, {63'd0, mon_e.d0});
`endif
            end
        end
    end

    // Issue one operation from a negedge with busy=0 and follow it to done.
    // mode 1: stray start and mthi mid-operation; mode 2: mtlo with start.
    task automatic op_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int mode);
        int n;
        MDOp  = op;
        A     = a;
        B     = b;
        start = 1'b1;
        if (mode == 2) begin
            mtlo  = 1'b1;
            wdata = 32'h77;
        end
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        start = 1'b0;
        mtlo  = 1'b0;
        if (mode == 2) check("mtlo_with_start", {32'd0, LO}, 64'h77);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div0_clear_on_start", {63'd0, div0}, 64'd0);
`endif
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (mode == 1 && n == 10) begin
                start = 1'b1;
                MDOp  = 2'b01;
                A     = 32'h1234_5678;
                B     = 32'h9;
                mthi  = 1'b1;
                wdata = 32'hAAAA;
            end else if (n == 11) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(ITER + 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        MDOp = 2'b00; A = '0; B = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_HI", {32'd0, HI}, 64'd0);
        check("rst_LO", {32'd0, LO}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        op_run(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        op_run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        op_run(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        op_run(2'b11, 32'd100, 32'd7, 0);
        op_run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        op_run(2'b11, 32'h1234, 32'd0, 0);
        op_run(2'b10, 32'hFFFF_FF00, 32'd0, 0);
        op_run(2'b00, 32'd3, 32'd4, 0);

        // MTLO / MTHI while idle
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'h55;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_idle", {32'd0, LO}, 64'h55);
        mthi = 1'b1; wdata = 32'h1357;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_idle", {32'd0, HI}, 64'h1357);

        op_run(2'b10, 32'd1000, 32'hFFFF_FFFD, 1);
        op_run(2'b01, 32'hDEAD_BEEF, 32'h10, 2);

        // Reset during RUN aborts without a done pulse
        @(negedge clk);
        MDOp = 2'b00; A = 32'd123; B = 32'd456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_HI", {32'd0, HI}, 64'd0);
        check("abort_LO", {32'd0, LO}, 64'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) n++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(n), 64'd0);
        op_run(2'b00, 32'd6, 32'd7, 0);

        for (int i = 0; i < 40; i++) begin
            op_run(2'($urandom_range(0, 3)), pick(), pick(), 0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
